// File: rtl/misc_branch_arbiter_pkg.sv
// Shared bundle layout for the misc branch and its requester arbiter.
// Fields are packed LSB-first in the order listed by the offset constants.
package misc_branch_arbiter_pkg;

  localparam int unsigned MISC_OP_W    = 4;
  localparam int unsigned MISC_SHIFT_W = 5;
  localparam int unsigned MISC_DEST_W  = 5;
  localparam int unsigned MISC_CID_W   = 4;

  function automatic int unsigned misc_blk_w(input int unsigned n_blocks);
    return (n_blocks > 1) ? $clog2(n_blocks) : 1;
  endfunction

  // block + arg_a/b/c + accumulator(2w) + op + sat_dis + shift + dest + commit_id + commit_flag
  function automatic int unsigned misc_req_w(input int unsigned data_width,
                                             input int unsigned n_blocks);
    return misc_blk_w(n_blocks) + 5 * data_width + MISC_OP_W + 1 + MISC_SHIFT_W
           + MISC_DEST_W + MISC_CID_W + 1;
  endfunction

  function automatic int unsigned misc_res_w(input int unsigned data_width,
                                             input int unsigned n_blocks);
    return misc_blk_w(n_blocks) + MISC_DEST_W + 2 * data_width + MISC_CID_W + 1;
  endfunction

  localparam int unsigned MISC_DATA_W   = 16;
  localparam int unsigned MISC_N_BLOCKS = 256;
  localparam int unsigned MISC_BLK_W    = misc_blk_w(MISC_N_BLOCKS);
  localparam int unsigned MISC_REQ_W    = misc_req_w(MISC_DATA_W, MISC_N_BLOCKS);
  localparam int unsigned MISC_RES_W    = misc_res_w(MISC_DATA_W, MISC_N_BLOCKS);

  localparam int unsigned REQ_BLOCK_LSB = 0;
  localparam int unsigned REQ_ARG_A_LSB = REQ_BLOCK_LSB + MISC_BLK_W;
  localparam int unsigned REQ_ARG_B_LSB = REQ_ARG_A_LSB + MISC_DATA_W;
  localparam int unsigned REQ_ARG_C_LSB = REQ_ARG_B_LSB + MISC_DATA_W;
  localparam int unsigned REQ_ACC_LSB   = REQ_ARG_C_LSB + MISC_DATA_W;
  localparam int unsigned REQ_OP_LSB    = REQ_ACC_LSB + 2 * MISC_DATA_W;
  localparam int unsigned REQ_SATD_LSB  = REQ_OP_LSB + MISC_OP_W;
  localparam int unsigned REQ_SHIFT_LSB = REQ_SATD_LSB + 1;
  localparam int unsigned REQ_DEST_LSB  = REQ_SHIFT_LSB + MISC_SHIFT_W;
  localparam int unsigned REQ_CID_LSB   = REQ_DEST_LSB + MISC_DEST_W;
  localparam int unsigned REQ_FLAG_LSB  = REQ_CID_LSB + MISC_CID_W;

  localparam int unsigned RES_BLOCK_LSB  = 0;
  localparam int unsigned RES_DEST_LSB   = RES_BLOCK_LSB + MISC_BLK_W;
  localparam int unsigned RES_RESULT_LSB = RES_DEST_LSB + MISC_DEST_W;
  localparam int unsigned RES_CID_LSB    = RES_RESULT_LSB + 2 * MISC_DATA_W;
  localparam int unsigned RES_FLAG_LSB   = RES_CID_LSB + MISC_CID_W;

endpackage

// File: rtl/tag_fifo.sv
// Circular FIFO of requester tags; remembers who owns each outstanding op.
// A push into a full FIFO is legal only together with a pop.
module tag_fifo #(
  parameter int width = 2,
  parameter int depth = 4,
  localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1,
  localparam int cnt_w = $clog2(depth) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [cnt_w-1:0] count
);

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;

  function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_data = mem[rd_ptr];
  assign empty     = (count == '0);
  assign full      = (count == cnt_w'(depth));

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/misc_branch_arbiter.sv
// Round-robin arbiter sharing one misc branch among n_req requesters.
// Results come back in issue order and are routed by a tag FIFO.
module misc_branch_arbiter
  import misc_branch_arbiter_pkg::*;
#(
  parameter int data_width   = 16,
  parameter int n_blocks     = 256,
  parameter int n_req        = 4,
  parameter int max_inflight = 4,
  localparam int req_w = misc_req_w(data_width, n_blocks),
  localparam int res_w = misc_res_w(data_width, n_blocks),
  localparam int idx_w = (n_req > 1) ? $clog2(n_req) : 1,
  localparam int cnt_w = $clog2(max_inflight) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [n_req-1:0]       req_valid,
  output logic [n_req-1:0]       req_ready,
  input  logic [n_req*req_w-1:0] req_payload,
  output logic                   unit_in_valid,
  input  logic                   unit_in_ready,
  output logic [req_w-1:0]       unit_payload,
  input  logic                   unit_out_valid,
  output logic                   unit_out_ready,
  input  logic [res_w-1:0]       unit_result,
  output logic [n_req-1:0]       resp_valid,
  input  logic [n_req-1:0]       resp_ready,
  output logic [res_w-1:0]       resp_result,
  output logic [cnt_w-1:0]       inflight_count,
  output logic                   error
);

  logic [idx_w-1:0] rr_ptr;
  logic [idx_w-1:0] winner;
  logic [idx_w-1:0] cand;
  logic [idx_w-1:0] head_tag;
  logic             any_req;
  logic             grant;
  logic             tag_pop;
  logic             tag_full;
  logic             tag_empty;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int i = 0; i < n_req; i++) begin
      cand = idx_w'((int'(rr_ptr) + i) % n_req);
      if (!any_req && req_valid[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  // A pop frees a FIFO slot in the same cycle, so a full FIFO can still grant.
  assign tag_pop = enable && !tag_empty && unit_out_valid && resp_ready[head_tag];
  assign grant   = enable && any_req && (!unit_in_valid || unit_in_ready)
                   && (!tag_full || tag_pop);

  // With nothing outstanding a result has no owner: drain it and flag it.
  always_comb begin
    req_ready      = '0;
    resp_valid     = '0;
    unit_out_ready = 1'b0;
    if (grant) req_ready[winner] = 1'b1;
    if (enable) begin
      if (tag_empty) begin
        unit_out_ready = 1'b1;
      end else begin
        unit_out_ready       = resp_ready[head_tag];
        resp_valid[head_tag] = unit_out_valid;
      end
    end
  end

  assign resp_result = unit_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr        <= '0;
      unit_in_valid <= 1'b0;
      error         <= 1'b0;
    end else if (enable) begin
      if (grant) begin
        unit_in_valid <= 1'b1;
        rr_ptr        <= (winner == idx_w'(n_req - 1)) ? '0 : winner + 1'b1;
      end else if (unit_in_ready) begin
        unit_in_valid <= 1'b0;
      end
      if (tag_empty && unit_out_valid) error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) unit_payload <= req_payload[winner*req_w +: req_w];
  end

  tag_fifo #(
    .width (idx_w),
    .depth (max_inflight)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (grant),
    .push_data (winner),
    .pop       (tag_pop),
    .head_data (head_tag),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (inflight_count)
  );

endmodule

// File: tb/tb_misc_branch_arbiter.sv
// Scoreboard bench for misc_branch_arbiter: directed scenarios, then random traffic
// checked against a queue-based reference model and an in-bench misc branch model.
module tb_misc_branch_arbiter;
  import misc_branch_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int MAXI  = 4;
  localparam int REQ_W = MISC_REQ_W;
  localparam int RES_W = MISC_RES_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*REQ_W-1:0] req_payload = '0;
  logic unit_in_valid;
  logic unit_in_ready = 1'b0;
  logic [REQ_W-1:0] unit_payload;
  logic unit_out_valid = 1'b0;
  logic unit_out_ready;
  logic [RES_W-1:0] unit_result = '0;
  logic [N-1:0] resp_valid;
  logic [N-1:0] resp_ready = '0;
  logic [RES_W-1:0] resp_result;
  logic [$clog2(MAXI):0] inflight_count;
  logic error;

  int n_checks = 0;
  int n_errors = 0;
  int dir_grant = -1;
  int dir_cnt = -1;
  int dir_uor = -1;
  bit end_chk = 1'b0;

  int m_tags[$];
  int m_ptr = 0;
  bit m_busy = 1'b0;
  bit m_err = 1'b0;
  logic [REQ_W-1:0] exp_issue_q[$];
  int exp_resp_idx[$];
  logic [RES_W-1:0] exp_resp_res[$];
  logic [RES_W-1:0] unit_pend[$];

  always #5 clk = ~clk;

  misc_branch_arbiter #(
    .data_width   (MISC_DATA_W),
    .n_blocks     (MISC_N_BLOCKS),
    .n_req        (N),
    .max_inflight (MAXI)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_payload    (req_payload),
    .unit_in_valid  (unit_in_valid),
    .unit_in_ready  (unit_in_ready),
    .unit_payload   (unit_payload),
    .unit_out_valid (unit_out_valid),
    .unit_out_ready (unit_out_ready),
    .unit_result    (unit_result),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_result    (resp_result),
    .inflight_count (inflight_count),
    .error          (error)
  );

  // What the misc branch computes for an op: acc + a*b, tagged with the op's ids.
  function automatic logic [RES_W-1:0] res_of(input logic [REQ_W-1:0] p);
    logic [RES_W-1:0] r;
    logic [2*MISC_DATA_W-1:0] acc;
    acc = p[REQ_ACC_LSB +: 2*MISC_DATA_W]
          + p[REQ_ARG_A_LSB +: MISC_DATA_W] * p[REQ_ARG_B_LSB +: MISC_DATA_W];
    r = '0;
    r[RES_BLOCK_LSB +: MISC_BLK_W]    = p[REQ_BLOCK_LSB +: MISC_BLK_W];
    r[RES_DEST_LSB +: MISC_DEST_W]    = p[REQ_DEST_LSB +: MISC_DEST_W];
    r[RES_RESULT_LSB +: 2*MISC_DATA_W] = acc;
    r[RES_CID_LSB +: MISC_CID_W]      = p[REQ_CID_LSB +: MISC_CID_W];
    r[RES_FLAG_LSB]                   = p[REQ_FLAG_LSB];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input bit en, input logic [N-1:0] rv, input bit uir, input bit allow,
                       input logic [N-1:0] rr, input bit spur,
                       input int dg, input int dc, input int du);
    logic [127:0] t;
    @(posedge clk);
    #1;
    reset         = 1'b0;
    enable        = en;
    req_valid     = rv;
    unit_in_ready = uir && en;
    resp_ready    = rr;
    for (int r = 0; r < N; r++) begin
      t = {$urandom, $urandom, $urandom, $urandom};
      req_payload[r*REQ_W +: REQ_W] = t[REQ_W-1:0];
    end
    if (unit_pend.size() > 0) begin
      unit_out_valid = allow;
      unit_result    = unit_pend[0];
    end else begin
      t = {$urandom, $urandom, $urandom, $urandom};
      unit_out_valid = spur;
      unit_result    = t[RES_W-1:0];
    end
    dir_grant = dg;
    dir_cnt   = dc;
    dir_uor   = du;
    end_chk   = 1'b0;
  endtask

  task automatic pulse_reset(input int n);
    @(posedge clk);
    #1;
    reset          = 1'b1;
    req_valid      = '0;
    unit_out_valid = 1'b0;
    unit_in_ready  = 1'b0;
    dir_grant      = -1;
    dir_cnt        = -1;
    dir_uor        = -1;
    repeat (n - 1) @(posedge clk);
  endtask

  // Reference model: round-robin grant, in-order tag routing, sticky spurious error.
  initial forever begin : model_chk
    int head, w, k, got;
    bit pop, can, was_empty;
    logic [N-1:0] e_rr, e_rv;
    bit e_uor;
    @(negedge clk);
    if (reset) begin
      m_ptr = 0;
      m_busy = 1'b0;
      m_err = 1'b0;
      m_tags.delete();
      exp_issue_q.delete();
      exp_resp_idx.delete();
      exp_resp_res.delete();
      unit_pend.delete();
    end else begin
      was_empty = (m_tags.size() == 0);
      head = was_empty ? 0 : m_tags[0];
      e_rv = '0;
      if (enable && !was_empty && unit_out_valid) e_rv[head] = 1'b1;
      e_uor = !enable ? 1'b0 : (was_empty ? 1'b1 : resp_ready[head]);
      pop = enable && !was_empty && unit_out_valid && resp_ready[head];
      can = enable && (!m_busy || unit_in_ready) && (m_tags.size() < MAXI || pop);
      w = -1;
      if (can) begin
        for (int i = 0; i < N; i++) begin
          k = (m_ptr + i) % N;
          if (w < 0 && req_valid[k]) w = k;
        end
      end
      e_rr = '0;
      if (w >= 0) e_rr[w] = 1'b1;

      chk("req_ready", req_ready, e_rr);
      chk("resp_valid", resp_valid, e_rv);
      chk("unit_out_ready", unit_out_ready, e_uor);
      chk("inflight_count", inflight_count, m_tags.size());
      chk("error", error, m_err);
      chk("unit_in_valid", unit_in_valid, m_busy);

      if (dir_grant != -1) begin
        got = -2;
        for (int r = 0; r < N; r++) if (req_ready[r]) got = r;
        chk("dir_grant", got, dir_grant);
      end
      if (dir_cnt != -1) chk("dir_count", inflight_count, dir_cnt);
      if (dir_uor != -1) chk("dir_unit_out_ready", unit_out_ready, dir_uor);
      if (end_chk) begin
        chk("drain_issue_q", exp_issue_q.size(), 0);
        chk("drain_resp_q", exp_resp_idx.size(), 0);
      end

      if (enable && was_empty && unit_out_valid) m_err = 1'b1;
      if (pop) void'(m_tags.pop_front());
      if (w >= 0) begin
        m_tags.push_back(w);
        exp_issue_q.push_back(req_payload[w*REQ_W +: REQ_W]);
        exp_resp_idx.push_back(w);
        exp_resp_res.push_back(res_of(req_payload[w*REQ_W +: REQ_W]));
        m_ptr = (w + 1) % N;
        m_busy = 1'b1;
      end else if (enable && unit_in_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  // Monitor: plays the misc branch and checks every issue/response handshake.
  initial forever begin : hs_monitor
    logic [REQ_W-1:0] e_pay;
    logic [RES_W-1:0] e_res;
    int e_idx;
    @(negedge clk);
    if (!reset && enable) begin
      if (unit_in_valid && unit_in_ready) begin
        if (exp_issue_q.size() == 0) begin
          chk("issue_unexpected", 1, 0);
        end else begin
          e_pay = exp_issue_q.pop_front();
          chk("issue_payload", unit_payload, e_pay);
        end
        unit_pend.push_back(res_of(unit_payload));
      end
      for (int r = 0; r < N; r++) begin
        if (resp_valid[r] && resp_ready[r]) begin
          if (exp_resp_idx.size() == 0) begin
            chk("resp_unexpected", r, 99);
          end else begin
            e_idx = exp_resp_idx.pop_front();
            e_res = exp_resp_res.pop_front();
            chk("resp_route", r, e_idx);
            chk("resp_result", resp_result, e_res);
          end
        end
      end
      if (unit_out_valid && unit_out_ready && unit_pend.size() > 0)
        void'(unit_pend.pop_front());
    end
  end

  initial begin
    pulse_reset(3);
    drive(1, '0, 1, 0, '1, 0, -2, 0, -1);

    // single op from requester 2
    pulse_reset(1);
    drive(1, 4'b0100, 1, 0, '1, 0, 2, 0, -1);
    drive(1, 4'b0000, 1, 0, '1, 0, -2, 1, -1);
    repeat (3) drive(1, 4'b0000, 1, 1, '1, 0, -1, -1, -1);

    // fairness with everyone requesting
    pulse_reset(1);
    for (int i = 0; i < 8; i++) drive(1, '1, 1, 1, '1, 0, i % 4, -1, -1);
    repeat (4) drive(1, '0, 1, 1, '1, 0, -1, -1, -1);

    // backpressure: no results return, FIFO fills at 4
    pulse_reset(1);
    for (int i = 0; i < 8; i++) drive(1, '1, 1, 0, '1, 0, (i < 4) ? i : -2, (i >= 4) ? 4 : -1, -1);
    drive(1, '1, 1, 1, '1, 0, 0, 4, -1);
    drive(1, '0, 1, 0, '1, 0, -2, 4, -1);

    // ordering with a stalled head requester
    pulse_reset(1);
    drive(1, 4'b1000, 1, 0, '1, 0, 3, -1, -1);
    drive(1, 4'b0010, 1, 0, '1, 0, 1, -1, -1);
    drive(1, 4'b0001, 1, 0, '1, 0, 0, -1, -1);
    drive(1, 4'b0000, 1, 0, '1, 0, -2, 3, -1);
    repeat (5) drive(1, '0, 1, 1, 4'b0111, 0, -1, 3, 0);
    repeat (6) drive(1, '0, 1, 1, '1, 0, -1, -1, -1);

    // reset with 3 ops outstanding
    pulse_reset(1);
    repeat (3) drive(1, '1, 1, 0, '1, 0, -1, -1, -1);
    drive(1, '0, 1, 0, '1, 0, -2, 3, -1);
    pulse_reset(1);
    drive(1, '1, 1, 0, '1, 0, 0, 0, -1);

    // spurious result with nothing outstanding
    pulse_reset(1);
    drive(1, '0, 1, 0, '1, 1, -2, 0, 1);
    repeat (3) drive(1, '0, 1, 0, '1, 0, -2, 0, -1);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset(1);
      drive($urandom_range(0, 9) != 0, N'($urandom), $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 6, N'($urandom), 0, -1, -1, -1);
    end

    repeat (30) drive(1, '0, 1, 1, '1, 0, -1, -1, -1);
    end_chk = 1'b1;
    drive(1, '0, 1, 1, '1, 0, -1, 0, -1);

    pulse_reset(2);
    drive(1, '0, 1, 0, '1, 0, -2, 0, -1);
    drive(1, '0, 1, 0, '1, 0, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
